ps2_keyboard_rx: RTL and testbench

Parametrised receive-only PS/2 keyboard front end. It performs these steps:
- synchronises and deglitches the PS/2 clock and data lines;
- captures 11-bit frames and checks start, parity and stop bits;
- decodes E0 (extended) and F0 (break) prefixes into make/break events.

Decoded events are buffered in a FIFO behind a valid/ready interface that feeds game/control logic. Parity, framing and timeout errors are reported as pulses, and FIFO overflow is reported as a sticky flag.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_frame_rx.sv | 162 ++++++++++++++++
 rtl/ps2_keyboard_rx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : extended and break prefix bytes
//   PS2_FRAME_BITS    : start + 8 data + parity + stop
//   ps2_evt_t         : decoded event {ext, brk, code}, PS2_EVT_W bits wide
//   dec_state_e       : prefix decoder states
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_EVT_W      = 10;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and deglitches ps2_clk/ps2_data,
// shifts in 11-bit frames on filtered clock falling edges and checks
// start, parity and stop bits. Aborts a partial frame after
// TIMEOUT_CYCLES clocks without a sample event.
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   ps2_clk, ps2_data    : raw PS/2 lines (inputs only)
//   rx_byte, byte_valid  : received byte, one-cycle strobe on a good frame
//   err_parity/frame/timeout : one-cycle error pulses
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);
  localparam logic [3:0] PAR_IDX  = 4'(PS2_FRAME_BITS - 2);

  // Channel 0 = clock line, channel 1 = data line.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  filt_q, filt_d;
  logic [1:0][FLT_W-1:0]       fcnt_q, fcnt_d;

  logic             fclk_prev_q, fclk_prev_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       byte_q, byte_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bvld_q, bvld_d;
  logic             eperr_q, eperr_d;
  logic             efrm_q, efrm_d;
  logic             etmo_q, etmo_d;

  logic fall;
  logic data_bit;

  assign raw = {ps2_data, ps2_clk};

  // Sync chain plus level filter: the filtered level only moves after
  // FILTER_LEN consecutive synced samples disagree with it.
  always_comb begin
    sync_d = sync_q;
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int c = 0; c < 2; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], raw[c]};
      if (sync_q[c][SYNC_STAGES-1] == filt_q[c]) begin
        fcnt_d[c] = '0;
      end else if (fcnt_q[c] == FLT_W'(FILTER_LEN - 1)) begin
        filt_d[c] = sync_q[c][SYNC_STAGES-1];
        fcnt_d[c] = '0;
      end else begin
        fcnt_d[c] = fcnt_q[c] + FLT_W'(1);
      end
    end
  end

  assign fclk_prev_d = filt_q[0];
  assign fall        = fclk_prev_q & ~filt_q[0];
  assign data_bit    = filt_q[1];

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_d    = byte_q;
    tmo_d     = tmo_q;
    bvld_d    = 1'b0;
    eperr_d   = 1'b0;
    efrm_d    = 1'b0;
    etmo_d    = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is rejected on the spot; stay hunting for a start.
        if (data_bit) efrm_d = 1'b1;
        else          bit_cnt_d = 4'd1;
      end else if (bit_cnt_q < PAR_IDX) begin
        shift_d   = {data_bit, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == PAR_IDX) begin
        par_d     = data_bit;
        bit_cnt_d = STOP_IDX;
      end else begin
        bit_cnt_d = 4'd0;
        if (!odd_parity_ok(shift_q, par_q)) begin
          eperr_d = 1'b1;
        end else if (!data_bit) begin
          efrm_d = 1'b1;
        end else begin
          bvld_d = 1'b1;
          byte_d = shift_q;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        etmo_d    = 1'b1;
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      filt_q      <= '1;
      fcnt_q      <= '0;
      fclk_prev_q <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      byte_q      <= '0;
      tmo_q       <= '0;
      bvld_q      <= 1'b0;
      eperr_q     <= 1'b0;
      efrm_q      <= 1'b0;
      etmo_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fclk_prev_q <= fclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_q      <= byte_d;
      tmo_q       <= tmo_d;
      bvld_q      <= bvld_d;
      eperr_q     <= eperr_d;
      efrm_q      <= efrm_d;
      etmo_q      <= etmo_d;
    end
  end

  assign rx_byte     = byte_q;
  assign byte_valid  = bvld_q;
  assign err_parity  = eperr_q;
  assign err_frame   = efrm_q;
  assign err_timeout = etmo_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end. Frames come from ps2_frame_rx;
// E0/F0 prefixes are folded into make/break events and queued in a
// first-word-fall-through FIFO behind a valid/ready interface.
// Ports:
//   clk, rst                     : system clock, synchronous active-high reset
//   ps2_clk, ps2_data            : raw PS/2 lines (never driven)
//   evt_code/evt_ext/evt_brk     : head event fields (0 when empty)
//   evt_valid, evt_ready         : FIFO non-empty / consumer accept
//   fifo_count                   : occupied entries
//   overflow, ovf_clr            : sticky drop flag and its clear
//   err_parity/frame/timeout     : one-cycle error pulses
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int REPORT_BREAK   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  output logic [7:0]                       evt_code,
  output logic                             evt_ext,
  output logic                             evt_brk,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow,
  input  logic                             ovf_clr,
  output logic                             err_parity,
  output logic                             err_frame,
  output logic                             err_timeout
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_eperr, rx_efrm, rx_etmo;
  logic       rx_err;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (rx_valid),
    .err_parity (rx_eperr),
    .err_frame  (rx_efrm),
    .err_timeout(rx_etmo)
  );

  assign rx_err      = rx_eperr | rx_efrm | rx_etmo;
  assign err_parity  = rx_eperr;
  assign err_frame   = rx_efrm;
  assign err_timeout = rx_etmo;

  // ---------------- prefix decoder ----------------
  dec_state_e state_q, state_d;
  logic       emit;
  ps2_evt_t   evt_new;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    evt_new = '0;
    if (rx_err) begin
      // Any line error drops a half-built prefix sequence.
      state_d = DEC_IDLE;
    end else if (rx_valid) begin
      evt_new.code = rx_byte;
      unique case (state_q)
        DEC_IDLE, DEC_BRK: begin
          // A prefix seen after F0 restarts the prefix sequence.
          if (rx_byte == PS2_EXT) begin
            state_d = DEC_EXT;
          end else if (rx_byte == PS2_BRK) begin
            state_d = DEC_BRK;
          end else begin
            emit        = 1'b1;
            evt_new.brk = (state_q == DEC_BRK);
            state_d     = DEC_IDLE;
          end
        end
        DEC_EXT: begin
          if (rx_byte == PS2_BRK) begin
            state_d = DEC_EXT_BRK;
          end else if (rx_byte == PS2_EXT) begin
            state_d = DEC_EXT;
          end else begin
            emit        = 1'b1;
            evt_new.ext = 1'b1;
            state_d     = DEC_IDLE;
          end
        end
        DEC_EXT_BRK: begin
          emit        = 1'b1;
          evt_new.ext = 1'b1;
          evt_new.brk = 1'b1;
          state_d     = DEC_IDLE;
        end
        default: state_d = DEC_IDLE;
      endcase
    end
  end

  // ---------------- event FIFO ----------------
  ps2_evt_t         mem_q [FIFO_DEPTH];
  ps2_evt_t         mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, wr_en, drop;
  ps2_evt_t         head;

  // Suppressed break events never reach the FIFO, so they cannot overflow it.
  assign push  = emit & (~evt_new.brk | (REPORT_BREAK != 0));
  assign pop   = evt_valid & evt_ready;
  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = evt_new;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // A drop in the same cycle as a clear wins.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DEC_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign evt_valid  = (cnt_q != '0);
  assign evt_code   = evt_valid ? head.code : 8'h00;
  assign evt_ext    = evt_valid & head.ext;
  assign evt_brk    = evt_valid & head.brk;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx. dut0: FIFO_DEPTH=4, breaks reported;
// dut1: FIFO_DEPTH=8, breaks discarded. Both watch the same PS/2 lines.
module tb_ps2_keyboard_rx;

  localparam int HALF = 20;    // PS/2 half bit period in clk cycles
  localparam int TMO  = 1000;
  // Raw stop-bit fall to evt_valid: 2 sync + 4 filter samples, fall detect,
  // byte strobe, FIFO write -> valid visible 8 clk edges after the raw fall.
  localparam int LAT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1, ps2_data = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;

  logic [7:0] code0, code1;
  logic       ext0, ext1, brk0, brk1, vld0, vld1, ovf0, ovf1;
  logic [2:0] cnt0;
  logic [3:0] cnt1;
  logic       perr0, ferr0, terr0, perr1, ferr1, terr1;

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_perr = 0, n_ferr = 0, n_tmo = 0, tmo_first = 0;
  int last_fall = 0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO), .REPORT_BREAK(1)) dut0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_code(code0), .evt_ext(ext0), .evt_brk(brk0), .evt_valid(vld0),
    .evt_ready(rdy0), .fifo_count(cnt0), .overflow(ovf0), .ovf_clr(clr0),
    .err_parity(perr0), .err_frame(ferr0), .err_timeout(terr0));

  ps2_keyboard_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO), .REPORT_BREAK(0)) dut1 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_code(code1), .evt_ext(ext1), .evt_brk(brk1), .evt_valid(vld1),
    .evt_ready(rdy1), .fifo_count(cnt1), .overflow(ovf1), .ovf_clr(clr1),
    .err_parity(perr1), .err_frame(ferr1), .err_timeout(terr1));

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (perr0) n_perr = n_perr + 1;
    if (ferr0) n_ferr = n_ferr + 1;
    if (terr0) begin
      if (n_tmo == 0) tmo_first = cyc;
      n_tmo = n_tmo + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // hook 1: latency check on stop bit; hook 2: pop exactly in the push cycle.
  task automatic send(input logic [7:0] b, input bit bad_par, input int nbits,
                      input int hook, input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_bit) begin
        repeat (HALF/2) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - HALF/2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (i == 10 && hook == 1) begin
        repeat (LAT-1) @(negedge clk);
        chk("lat_before", 32'(vld0), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(vld0), 32'd1);
        repeat (HALF - LAT) @(negedge clk);
      end else if (i == 10 && hook == 2) begin
        repeat (LAT-1) @(negedge clk);
        chk("full_head", 32'(code0), 32'h16);
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        chk("full_pushpop_cnt", 32'(cnt0), 32'd4);
        chk("full_pushpop_ovf", 32'(ovf0), 32'd0);
        repeat (HALF - LAT) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic sendb(input logic [7:0] b);
    send(b, 1'b0, 11, 0, -1);
  endtask

  task automatic pop_evt(input int d, input string tag, input logic [9:0] exp);
    @(negedge clk);
    if (d == 0) begin
      chk(tag, {21'd0, vld0, ext0, brk0, code0}, {21'd0, 1'b1, exp});
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
    end else begin
      chk(tag, {21'd0, vld1, ext1, brk1, code1}, {21'd0, 1'b1, exp});
      rdy1 = 1'b1;
      @(negedge clk);
      rdy1 = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bp, bf;
    do_reset();
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_evt", {22'd0, ext0, brk0, code0}, 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_errs", {29'd0, perr0, ferr0, terr0}, 32'd0);

    // make then break of 1C
    send(8'h1C, 1'b0, 11, 1, -1);
    pop_evt(0, "make_1C", {2'b00, 8'h1C});
    sendb(8'hF0); sendb(8'h1C);
    pop_evt(0, "brk_1C", {2'b01, 8'h1C});
    chk("brk_empty", 32'(vld0), 32'd0);
    pop_evt(1, "nobrk_make_1C", {2'b00, 8'h1C});
    chk("nobrk_drop", 32'(vld1), 32'd0);

    // extended make / break
    do_reset();
    sendb(8'hE0); sendb(8'h75);
    sendb(8'hE0); sendb(8'hF0); sendb(8'h75);
    pop_evt(0, "ext_make_75", {2'b10, 8'h75});
    pop_evt(0, "ext_brk_75", {2'b11, 8'h75});
    pop_evt(1, "nobrk_ext_75", {2'b10, 8'h75});
    chk("nobrk_ext_only", 32'(vld1), 32'd0);
    chk("nobrk_no_ovf", 32'(ovf1), 32'd0);

    // parity errors
    do_reset();
    bp = n_perr; bf = n_ferr;
    send(8'h1C, 1'b1, 11, 0, -1);
    chk("perr_pulse", 32'(n_perr - bp), 32'd1);
    chk("perr_no_ferr", 32'(n_ferr - bf), 32'd0);
    chk("perr_no_evt", 32'(vld0), 32'd0);
    sendb(8'h32);
    pop_evt(0, "after_perr_32", {2'b00, 8'h32});
    sendb(8'hF0);
    send(8'h55, 1'b1, 11, 0, -1);
    sendb(8'h1C);
    pop_evt(0, "perr_resets_dec", {2'b00, 8'h1C});
    chk("perr_pulse2", 32'(n_perr - bp), 32'd2);

    // timeout on a partial frame
    do_reset();
    send(8'h1C, 1'b0, 5, 0, -1);
    repeat (TMO + 50) @(negedge clk);
    chk("tmo_pulse", 32'(n_tmo), 32'd1);
    chk("tmo_when", 32'((tmo_first - last_fall) >= TMO && (tmo_first - last_fall) <= TMO + 10), 32'd1);
    sendb(8'h1C);
    pop_evt(0, "after_tmo_1C", {2'b00, 8'h1C});
    chk("after_tmo_empty", 32'(vld0), 32'd0);

    // overflow on a depth-4 FIFO
    do_reset();
    sendb(8'h16); sendb(8'h1E); sendb(8'h26); sendb(8'h25); sendb(8'h2E);
    chk("ovf_count", 32'(cnt0), 32'd4);
    chk("ovf_set", 32'(ovf0), 32'd1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    chk("ovf_clr", 32'(ovf0), 32'd0);
    send(8'h36, 1'b0, 11, 2, -1);
    pop_evt(0, "drain_1E", {2'b00, 8'h1E});
    pop_evt(0, "drain_26", {2'b00, 8'h26});
    pop_evt(0, "drain_25", {2'b00, 8'h25});
    pop_evt(0, "drain_36", {2'b00, 8'h36});
    chk("drain_empty", 32'(cnt0), 32'd0);

    // glitch on ps2_clk mid-frame
    do_reset();
    bp = n_perr; bf = n_ferr;
    send(8'h4B, 1'b0, 11, 0, 4);
    pop_evt(0, "glitch_4B", {2'b00, 8'h4B});
    chk("glitch_noerr", 32'((n_perr - bp) + (n_ferr - bf)), 32'd0);

    // reset mid-frame
    sendb(8'h1C);
    send(8'h2D, 1'b0, 5, 0, -1);
    bf = n_ferr;
    do_reset();
    chk("midrst_out", {19'd0, vld0, cnt0, ovf0, ext0, brk0, code0}, 32'd0);
    sendb(8'h32);
    pop_evt(0, "midrst_32", {2'b00, 8'h32});
    chk("midrst_noferr", 32'(n_ferr - bf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
